vga_timing_gen: RTL
===================

# vga_timing_gen

Timing generator that consumes the packed VGA control-register bus (TIMR0–TIMR9, VGACR0) and produces horizontal/vertical sync, display-enable, pixel coordinates and frame/line/vblank event pulses. It sits directly downstream of the VGA MMIO register bank and upstream of the pixel fetch/output stage. Timing registers are shadowed at frame boundaries, so CPU writes never tear a frame.

## Interface
- DATA_WIDTH, 8, width of each control register
- NUM_VGA_CONT_REG, 11, number of packed registers on control_reg_in
- CNT_WIDTH, 13, width of the h/v counters and coordinate outputs
- clock  in  1  system/pixel clock; same domain as the register bank
- reset  in  1  reset, synchronous, active-high
- pix_ce  in  1  pixel clock enable; counters advance only on cycles with pix_ce=1
- control_reg_in  in  NUM_VGA_CONT_REG*DATA_WIDTH  packed registers; register n at bits [8n+7:8n]
- hsync  out  1  horizontal sync, polarity per VGACR0[1]
- vsync  out  1  vertical sync, polarity per VGACR0[2]
- de  out  1  display enable (active region)
- pixel_x  out  CNT_WIDTH  horizontal counter
- pixel_y  out  CNT_WIDTH  vertical counter
- line_start  out  1  one-clock pulse at each pixel_x=0
- frame_start  out  1  one-clock pulse at pixel_x=0, pixel_y=0
- vblank_irq  out  1  one-clock pulse on entry to vertical blanking

## Operation
- Register map: h_active = {TIMR1[3:0], TIMR0}; TIMR2 h_front; TIMR3 h_sync; TIMR4 h_back; v_active = {TIMR6[3:0], TIMR5}; TIMR7 v_front; TIMR8 v_sync; TIMR9 v_back. TIMR1[7:4], TIMR6[7:4] ignored.
- VGACR0: bit0 enable; bit1 hsync active-high (0 = active-low); bit2 vsync active-high; bit3 vblank_irq enable; bits 7:4 ignored.
- Totals: h_total = h_active+h_front+h_sync+h_back, computed at CNT_WIDTH (max 4860, no overflow); likewise v_total.
- FSM states: IDLE, RUN.
- IDLE: counters 0, de=0, syncs at inactive level, no pulses. On a pix_ce tick with enable=1, h_active≠0 and v_active≠0: load shadow timing, go to RUN, pixel_x=pixel_y=0, pulse frame_start and line_start.
- RUN, per pix_ce tick: pixel_x increments; at h_total-1 wraps to 0 and pixel_y increments; at pixel_y=v_total-1 with wrap, pixel_y=0 (new frame), shadow reloads from control_reg_in.
- At a frame wrap, if enable=0 or either new active size is 0, go to IDLE instead. Clearing enable mid-frame takes effect at the next pix_ce tick: immediate return to IDLE.
- Polarity bits sampled live (not shadowed).
- de = pixel_x<h_active && pixel_y<v_active.
- hsync asserted while h_active+h_front ≤ pixel_x < h_active+h_front+h_sync.
- vsync asserted while v_active+v_front ≤ pixel_y < v_active+v_front+v_sync; changes only with pixel_x=0.
- vblank_irq pulses when pixel_y becomes v_active, only if VGACR0[3]=1.
- Zero-length porch/sync fields are legal; the phase is absent (zero h_sync: hsync never asserts).

## Timing
- All outputs registered; outputs reflect the counter values updated on the pix_ce tick, visible the following cycle; stable while pix_ce=0.
- Pulses last exactly one clock cycle regardless of pix_ce rate.
- Reset: state IDLE, pixel_x=pixel_y=0, de=0, line_start=frame_start=vblank_irq=0, hsync=vsync=1 (active-low inactive level), shadow cleared. Reset mid-frame aborts immediately.
- Latency enable→first frame_start: first pix_ce tick after enable seen, +1 cycle.
- Frame period: h_total*v_total pix_ce ticks.

## Structure
- Shared package vga_pkg: register indices (TIMR0..TIMR9, VGACR0 = 10), VGACR0 bit positions, FSM state enum, CNT_WIDTH default.
- One sub-module vga_axis_counter (count, wrap at total-1, active/sync window compare), instantiated for H and V; V instance advanced by the H wrap.

## Test plan
- Reset: assert reset mid-RUN -> next cycle state IDLE, pixel_x=pixel_y=0, de=0, hsync=vsync=1, all pulses 0.
- Small mode: h=8/2/3/1, v=4/1/2/1, VGACR0=0x01, pix_ce=1 -> h_total 14, hsync low at pixel_x 10..12, vsync low on lines 5..6, de high 32 ticks/frame, frame_start every 112 cycles.
- Same mode, pix_ce every other cycle, VGACR0=0x0F -> frame period 224 cycles, syncs active-high, vblank_irq once per frame at pixel_y=4 entry, pulses 1 cycle wide.
- Write TIMR0=12 mid-frame -> current frame keeps h_total 14; next frame h_total 18.
- h_sync=0, h_front=0 -> hsync never asserts, h_total 9, de timing unchanged.
- Clear enable mid-line -> IDLE next tick; set TIMR5=0,TIMR6=0 then enable -> remains IDLE, no frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Register indices, VGACR0 bit positions and FSM states shared
//               by the VGA timing generator files.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned c_CNT_WIDTH = 13;

    localparam int unsigned c_TIMR0  = 0;
    localparam int unsigned c_TIMR1  = 1;
    localparam int unsigned c_TIMR2  = 2;
    localparam int unsigned c_TIMR3  = 3;
    localparam int unsigned c_TIMR4  = 4;
    localparam int unsigned c_TIMR5  = 5;
    localparam int unsigned c_TIMR6  = 6;
    localparam int unsigned c_TIMR7  = 7;
    localparam int unsigned c_TIMR8  = 8;
    localparam int unsigned c_TIMR9  = 9;
    localparam int unsigned c_VGACR0 = 10;

    localparam int unsigned c_CR0_ENABLE    = 0;
    localparam int unsigned c_CR0_HSYNC_POL = 1;
    localparam int unsigned c_CR0_VSYNC_POL = 2;
    localparam int unsigned c_CR0_IRQ_EN    = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Register-bus input and sync/coordinate outputs of the VGA
//               timing generator; master is the generator side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int NUM_VGA_CONT_REG = 11,
    parameter int CNT_WIDTH        = c_CNT_WIDTH
);
    logic                                   pix_ce;
    logic [NUM_VGA_CONT_REG*DATA_WIDTH-1:0] control_reg_in;
    logic                                   hsync;
    logic                                   vsync;
    logic                                   de;
    logic [CNT_WIDTH-1:0]                   pixel_x;
    logic [CNT_WIDTH-1:0]                   pixel_y;
    logic                                   line_start;
    logic                                   frame_start;
    logic                                   vblank_irq;

    modport master (
        input  pix_ce, control_reg_in,
        output hsync, vsync, de, pixel_x, pixel_y,
               line_start, frame_start, vblank_irq
    );

    modport slave (
        output pix_ce, control_reg_in,
        input  hsync, vsync, de, pixel_x, pixel_y,
               line_start, frame_start, vblank_irq
    );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One timing axis: counter wrapping at total-1 plus active and
//               sync window compares evaluated on the upcoming count value.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CNT_WIDTH = c_CNT_WIDTH
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_clear,
    input  wire logic                 i_advance,
    input  wire logic [CNT_WIDTH-1:0] i_cur_active,
    input  wire logic [CNT_WIDTH-1:0] i_cur_front,
    input  wire logic [CNT_WIDTH-1:0] i_cur_sync,
    input  wire logic [CNT_WIDTH-1:0] i_cur_back,
    input  wire logic [CNT_WIDTH-1:0] i_nxt_active,
    input  wire logic [CNT_WIDTH-1:0] i_nxt_front,
    input  wire logic [CNT_WIDTH-1:0] i_nxt_sync,
    output logic      [CNT_WIDTH-1:0] o_count,
    output logic      [CNT_WIDTH-1:0] o_next_count,
    output logic                      o_wrap,
    output logic                      o_next_active,
    output logic                      o_next_sync
);
    localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_total;
    logic [CNT_WIDTH-1:0] w_next;
    logic [CNT_WIDTH-1:0] w_sync_lo;
    logic [CNT_WIDTH-1:0] w_sync_hi;

    // Wrap uses the timing of the frame in progress; windows use the timing
    // that will apply to the value being loaded (new shadow on a reload).
    always_comb begin
        w_total   = i_cur_active + i_cur_front + i_cur_sync + i_cur_back;
        o_wrap    = (r_count == (w_total - c_ONE));
        w_next    = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_advance) begin
            w_next = o_wrap ? '0 : (r_count + c_ONE);
        end
        w_sync_lo     = i_nxt_active + i_nxt_front;
        w_sync_hi     = w_sync_lo + i_nxt_sync;
        o_next_active = (w_next < i_nxt_active);
        o_next_sync   = (w_next >= w_sync_lo) && (w_next < w_sync_hi);
        o_next_count  = w_next;
        o_count       = r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA sync/DE/coordinate generator driven by the packed control
//               registers, with timing shadowed at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int NUM_VGA_CONT_REG = 11,
    parameter int CNT_WIDTH        = c_CNT_WIDTH
) (
    input  wire logic        clock,
    input  wire logic        reset,
    vga_timing_gen_if.master bus
);
    logic [DATA_WIDTH-1:0] w_reg [NUM_VGA_CONT_REG];

    generate
        for (genvar gi = 0; gi < NUM_VGA_CONT_REG; gi++) begin : g_unpack
            assign w_reg[gi] = bus.control_reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [CNT_WIDTH-1:0] w_live_h_active, w_live_h_front, w_live_h_sync, w_live_h_back;
    logic [CNT_WIDTH-1:0] w_live_v_active, w_live_v_front, w_live_v_sync, w_live_v_back;
    logic                 w_enable, w_hpol, w_vpol, w_irq_en, w_live_ok;
    logic                 w_unused_bits;

    assign w_live_h_active = CNT_WIDTH'({w_reg[c_TIMR1][3:0], w_reg[c_TIMR0]});
    assign w_live_h_front  = CNT_WIDTH'(w_reg[c_TIMR2]);
    assign w_live_h_sync   = CNT_WIDTH'(w_reg[c_TIMR3]);
    assign w_live_h_back   = CNT_WIDTH'(w_reg[c_TIMR4]);
    assign w_live_v_active = CNT_WIDTH'({w_reg[c_TIMR6][3:0], w_reg[c_TIMR5]});
    assign w_live_v_front  = CNT_WIDTH'(w_reg[c_TIMR7]);
    assign w_live_v_sync   = CNT_WIDTH'(w_reg[c_TIMR8]);
    assign w_live_v_back   = CNT_WIDTH'(w_reg[c_TIMR9]);
    assign w_enable        = w_reg[c_VGACR0][c_CR0_ENABLE];
    assign w_hpol          = w_reg[c_VGACR0][c_CR0_HSYNC_POL];
    assign w_vpol          = w_reg[c_VGACR0][c_CR0_VSYNC_POL];
    assign w_irq_en        = w_reg[c_VGACR0][c_CR0_IRQ_EN];
    assign w_live_ok       = w_enable && (w_live_h_active != '0) && (w_live_v_active != '0);
    assign w_unused_bits   = ^{w_reg[c_TIMR1][DATA_WIDTH-1:4], w_reg[c_TIMR6][DATA_WIDTH-1:4],
                               w_reg[c_VGACR0][DATA_WIDTH-1:4]};

    state_t r_state, w_state_nxt;
    logic   w_load, w_clear, w_adv, w_line_pulse, w_frame_pulse, w_run_nxt;

    logic [CNT_WIDTH-1:0] r_sh_h_active, r_sh_h_front, r_sh_h_sync, r_sh_h_back;
    logic [CNT_WIDTH-1:0] r_sh_v_active, r_sh_v_front, r_sh_v_sync, r_sh_v_back;
    logic [CNT_WIDTH-1:0] w_nxt_h_active, w_nxt_h_front, w_nxt_h_sync;
    logic [CNT_WIDTH-1:0] w_nxt_v_active, w_nxt_v_front, w_nxt_v_sync;

    logic [CNT_WIDTH-1:0] w_h_count, w_h_next, w_v_count, w_v_next;
    logic                 w_h_wrap, w_h_next_active, w_h_next_sync;
    logic                 w_v_wrap, w_v_next_active, w_v_next_sync;

    assign w_nxt_h_active = w_load ? w_live_h_active : r_sh_h_active;
    assign w_nxt_h_front  = w_load ? w_live_h_front  : r_sh_h_front;
    assign w_nxt_h_sync   = w_load ? w_live_h_sync   : r_sh_h_sync;
    assign w_nxt_v_active = w_load ? w_live_v_active : r_sh_v_active;
    assign w_nxt_v_front  = w_load ? w_live_v_front  : r_sh_v_front;
    assign w_nxt_v_sync   = w_load ? w_live_v_sync   : r_sh_v_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_adv         = 1'b0;
        w_line_pulse  = 1'b0;
        w_frame_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pix_ce) begin
                    w_clear = 1'b1;
                    if (w_live_ok) begin
                        w_load        = 1'b1;
                        w_state_nxt   = RUN;
                        w_line_pulse  = 1'b1;
                        w_frame_pulse = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.pix_ce) begin
                    if (!w_enable) begin
                        w_clear     = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_h_wrap && w_v_wrap) begin
                        // Frame boundary: restart with fresh timing or drop out
                        w_clear = 1'b1;
                        if (w_live_ok) begin
                            w_load        = 1'b1;
                            w_line_pulse  = 1'b1;
                            w_frame_pulse = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_adv        = 1'b1;
                        w_line_pulse = w_h_wrap;
                    end
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sh_h_active <= '0;
            r_sh_h_front  <= '0;
            r_sh_h_sync   <= '0;
            r_sh_h_back   <= '0;
            r_sh_v_active <= '0;
            r_sh_v_front  <= '0;
            r_sh_v_sync   <= '0;
            r_sh_v_back   <= '0;
        end else if (w_load) begin
            r_sh_h_active <= w_live_h_active;
            r_sh_h_front  <= w_live_h_front;
            r_sh_h_sync   <= w_live_h_sync;
            r_sh_h_back   <= w_live_h_back;
            r_sh_v_active <= w_live_v_active;
            r_sh_v_front  <= w_live_v_front;
            r_sh_v_sync   <= w_live_v_sync;
            r_sh_v_back   <= w_live_v_back;
        end
    end

    vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_h_axis (
        .clk           (clock),
        .rst           (reset),
        .i_clear       (w_clear),
        .i_advance     (w_adv),
        .i_cur_active  (r_sh_h_active),
        .i_cur_front   (r_sh_h_front),
        .i_cur_sync    (r_sh_h_sync),
        .i_cur_back    (r_sh_h_back),
        .i_nxt_active  (w_nxt_h_active),
        .i_nxt_front   (w_nxt_h_front),
        .i_nxt_sync    (w_nxt_h_sync),
        .o_count       (w_h_count),
        .o_next_count  (w_h_next),
        .o_wrap        (w_h_wrap),
        .o_next_active (w_h_next_active),
        .o_next_sync   (w_h_next_sync)
    );

    vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_v_axis (
        .clk           (clock),
        .rst           (reset),
        .i_clear       (w_clear),
        .i_advance     (w_adv && w_h_wrap),
        .i_cur_active  (r_sh_v_active),
        .i_cur_front   (r_sh_v_front),
        .i_cur_sync    (r_sh_v_sync),
        .i_cur_back    (r_sh_v_back),
        .i_nxt_active  (w_nxt_v_active),
        .i_nxt_front   (w_nxt_v_front),
        .i_nxt_sync    (w_nxt_v_sync),
        .o_count       (w_v_count),
        .o_next_count  (w_v_next),
        .o_wrap        (w_v_wrap),
        .o_next_active (w_v_next_active),
        .o_next_sync   (w_v_next_sync)
    );

    logic r_de, r_hsync, r_vsync, r_line_start, r_frame_start, r_vblank_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_de          <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
        end else begin
            r_line_start  <= w_line_pulse;
            r_frame_start <= w_frame_pulse;
            r_vblank_irq  <= w_adv && w_irq_en && (w_h_next == '0) && (w_v_next == r_sh_v_active);
            if (bus.pix_ce) begin
                r_de    <= w_run_nxt && w_h_next_active && w_v_next_active;
                r_hsync <= (w_run_nxt && w_h_next_sync) ? w_hpol : ~w_hpol;
                r_vsync <= (w_run_nxt && w_v_next_sync) ? w_vpol : ~w_vpol;
            end
        end
    end

    assign bus.pixel_x     = w_h_count;
    assign bus.pixel_y     = w_v_count;
    assign bus.de          = r_de;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.vblank_irq  = r_vblank_irq;

endmodule
`default_nettype wire
